// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient}
// for the HI/LO write, one quotient bit per cycle.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [WIDTH-1:0]   rem, rem_nxt;
   logic [WIDTH-1:0]   dvd, dvd_nxt;
   logic [WIDTH-1:0]   dsr, dsr_nxt;
   logic               neg_q, neg_q_nxt;
   logic               neg_r, neg_r_nxt;
   logic [2*WIDTH-1:0] result_nxt;
   logic               ready_nxt;

   logic [WIDTH:0]     part;
   logic               fits;
   logic [WIDTH-1:0]   quo_step, rem_step, quo_fin, rem_fin;

   // Two's-complement magnitude; 0x80..0 maps to itself as an unsigned value.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= FREE;
         cnt      <= '0;
         rem      <= '0;
         dvd      <= '0;
         dsr      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         rem      <= rem_nxt;
         dvd      <= dvd_nxt;
         dsr      <= dsr_nxt;
         neg_q    <= neg_q_nxt;
         neg_r    <= neg_r_nxt;
         result_o <= result_nxt;
         ready_o  <= ready_nxt;
      end
   end

   always_comb begin
      // One restoring step: the dividend MSB shifts into the partial remainder.
      part     = {rem, dvd[WIDTH-1]};
      fits     = part >= {1'b0, dsr};
      quo_step = {dvd[WIDTH-2:0], fits};
      rem_step = fits ? (part[WIDTH-1:0] - dsr) : part[WIDTH-1:0];
      quo_fin  = neg_q ? -quo_step : quo_step;
      rem_fin  = neg_r ? -rem_step : rem_step;

      state_nxt  = state;
      cnt_nxt    = cnt;
      rem_nxt    = rem;
      dvd_nxt    = dvd;
      dsr_nxt    = dsr;
      neg_q_nxt  = neg_q;
      neg_r_nxt  = neg_r;
      result_nxt = '0;
      ready_nxt  = 1'b0;

      unique case (state)
         FREE: begin
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_nxt = BYZERO;
               end else begin
                  state_nxt = ON;
                  cnt_nxt   = '0;
                  rem_nxt   = '0;
                  if (signed_div_i) begin
                     dvd_nxt   = mag(opdata1_i);
                     dsr_nxt   = mag(opdata2_i);
                     neg_q_nxt = opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1];
                     neg_r_nxt = opdata1_i[WIDTH-1];
                  end else begin
                     dvd_nxt   = opdata1_i;
                     dsr_nxt   = opdata2_i;
                     neg_q_nxt = 1'b0;
                     neg_r_nxt = 1'b0;
                  end
               end
            end
         end
         BYZERO: begin
            state_nxt = END;
            ready_nxt = 1'b1;
         end
         ON: begin
            if (annul_i) begin
               state_nxt = FREE;
            end else begin
               rem_nxt = rem_step;
               dvd_nxt = quo_step;
               cnt_nxt = cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state_nxt  = END;
                  result_nxt = {rem_fin, quo_fin};
                  ready_nxt  = 1'b1;
               end
            end
         end
         END: begin
            if (start_i) begin
               result_nxt = result_o;
               ready_nxt  = 1'b1;
            end else begin
               state_nxt = FREE;
            end
         end
         default: state_nxt = FREE;
      endcase
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotient/remainder pairs, latency,
// hold/release handshake, annul and asynchronous reset.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int n_cmp = 0;
   int n_bad = 0;

   div_unit #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Start a division at the next edge (E0), hold start, measure latency,
   // check one extra held cycle, then drop start and check the release.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
      int lat;
      @(negedge clk);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      @(posedge clk);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (ready_o) begin
            lat = i;
            break;
         end
      end
      chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, " result"}, result_o, exp);
      @(posedge clk);
      #1;
      chk({tag, " hold ready"}, 64'(ready_o), 64'd1);
      chk({tag, " hold result"}, result_o, exp);
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, " release ready"}, 64'(ready_o), 64'd0);
      chk({tag, " release result"}, result_o, 64'd0);
   endtask

   initial begin
      int highs;
      rst          = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset ready", 64'(ready_o), 64'd0);
      chk("reset result", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      run_div("u 100/7",       1'b0, 32'd100,        32'd7,          {32'h2, 32'hE}, 32);
      run_div("s -7/2",        1'b1, 32'hFFFF_FFF9,  32'h2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 32);
      run_div("s 7/-2",        1'b1, 32'h7,          32'hFFFF_FFFE,  {32'h1, 32'hFFFF_FFFD}, 32);
      run_div("s -100/-7",     1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE, 32'hE}, 32);
      run_div("s min/-1",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0, 32'h8000_0000}, 32);
      run_div("u min/max",     1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'h0}, 32);
      run_div("u div0",        1'b0, 32'd55,         32'd0,          64'd0, 1);
      run_div("s div0",        1'b1, 32'hFFFF_FFF0,  32'd0,          64'd0, 1);

      // Annul on the 10th iteration edge; no result may ever appear.
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'h1234_5678;
      opdata2_i    = 32'd3;
      start_i      = 1'b1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      start_i = 1'b0;
      @(posedge clk);
      #1;
      chk("annul ready", 64'(ready_o), 64'd0);
      @(negedge clk);
      annul_i = 1'b0;
      highs = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (ready_o) highs++;
      end
      chk("annul no ready", 64'(highs), 64'd0);
      run_div("u max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 32);

      // Asynchronous reset between edges, mid-iteration.
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      #3;
      rst     = 1'b0;
      start_i = 1'b0;
      #1;
      chk("rst mid ready", 64'(ready_o), 64'd0);
      chk("rst mid result", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Asynchronous reset while a result is being held.
      @(negedge clk);
      opdata1_i = 32'd1000;
      opdata2_i = 32'd3;
      start_i   = 1'b1;
      repeat (35) @(posedge clk);
      #1;
      chk("pre-rst end ready", 64'(ready_o), 64'd1);
      chk("pre-rst end result", result_o, {32'h1, 32'd333});
      #2;
      rst     = 1'b0;
      start_i = 1'b0;
      #1;
      chk("rst end ready", 64'(ready_o), 64'd0);
      chk("rst end result", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      run_div("u 100/7 after rst", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle radix-2 integer divider for the MIPS datapath, serving DIV and DIVU. It accepts a start request from the execute stage, iterates one quotient bit per cycle, and returns a 64-bit {remainder, quotient} result. The result feeds the HI/LO register: hi_i takes result_o[63:32] and lo_i takes result_o[31:0], with the write enable qualified by ready_o. Execute stalls the pipeline while a division is in flight.

## Interface
- WIDTH, 32, operand width; result_o is 2*WIDTH.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
- opdata1_i  in  WIDTH  dividend; sampled with start_i.
- opdata2_i  in  WIDTH  divisor; sampled with start_i.
- start_i  in  1  request; held high by execute until ready_o is seen.
- annul_i  in  1  abort (branch flush or exception); cancels any request or iteration.
- result_o  out  2*WIDTH  {remainder, quotient}; valid only while ready_o = 1, otherwise 0.
- ready_o  out  1  result valid.

## Operation
- States: FREE, BYZERO, ON, END. All outputs are registered.
- Reset (rst = 0, at any time, including mid-operation): state FREE, ready_o = 0, result_o = 0, counter and working registers = 0.
- FREE:
  - If start_i = 1, annul_i = 0 and divisor = 0: go to BYZERO.
  - If start_i = 1, annul_i = 0 and divisor ≠ 0: latch operands and go to ON.
    - Signed mode: latch |opdata1_i| and |opdata2_i|, and record both sign bits.
    - Unsigned mode: latch the raw operands.
    - Clear the iteration counter to 0.
  - Otherwise stay in FREE with ready_o = 0.
- BYZERO: next state END with result_o = 0 (quotient 0, remainder 0).
- ON:
  - If annul_i = 1: go to FREE immediately; ready_o stays 0 and result_o stays 0.
  - Else perform one restoring step:
    - Shift {partial remainder, dividend} left by 1.
    - Trial-subtract the divisor from the upper WIDTH+1 bits.
    - If the result is non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
    - Increment the counter.
  - After step WIDTH:
    - Signed mode only: negate the quotient if the operand signs differ; negate the remainder if the dividend was negative.
    - Register result_o, set ready_o = 1, go to END.
- END:
  - Hold result_o and ready_o = 1 while start_i = 1.
  - On the first edge with start_i = 0: go to FREE, ready_o = 0, result_o = 0.
  - annul_i has no effect in END.
- start_i, signed_div_i and the operands are ignored outside FREE.
- Width and arithmetic rules:
  - Magnitudes are treated as WIDTH-bit unsigned, so |0x80000000| = 0x80000000.
  - Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 and remainder 0; the wrap is deliberate and not flagged.
  - The remainder sign always follows the dividend; quotients truncate toward zero.

## Timing
- Let E0 be the edge that samples start_i in FREE.
- Normal division:
  - Iterations occur on E1..E32.
  - ready_o and result_o are high/valid after E32: latency 32 cycles from E0, 33 edges including E0.
- Divide by zero: BYZERO after E0; END with ready_o = 1 after E1.
- ready_o stays high at least one cycle. It stays high for as long as start_i stays high.
- Back-to-back divisions: after the END→FREE edge, the next start is sampled no earlier than the following edge.
- annul_i asserted during ON takes effect on the next edge; state is FREE after that edge.
- Throughput: one division per 34 cycles minimum.

## Test plan
- Unsigned 100 / 7, start held → ready_o rises 32 cycles after E0 with result_o = {0x00000002, 0x0000000E}; falls one edge after start_i drops, and result_o returns to 0.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0; the same operands unsigned → quotient 0, remainder 0x80000000.
- Divisor 0, either mode → ready_o high after E1, result_o = 0.
- annul_i pulsed during iteration 10 → FREE next edge and ready_o never rises; then unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0, ready_o after E32.
- rst driven low asynchronously mid-ON, between edges → ready_o and result_o go to 0 immediately; after release, a fresh 100 / 7 completes correctly with no residue from the aborted division.
